// File: rtl/rom_load_sequencer_if.sv
// rom_load_sequencer_if
//   Bundles the HPS download port and the core ROM write port that pass
//   through the ROM load sequencer.
//   Signals:
//     dn_download  download in progress (level)
//     dn_wr        byte write strobe, one cycle per byte
//     dn_addr      16-bit byte address of the download stream
//     dn_data      byte data
//     rom_we       one-hot region write enable (NUM_REGIONS wide)
//     rom_addr     byte offset within the selected region
//     rom_data     write data to the ROM region
//   Modports:
//     master  loader side: drives dn_*, observes rom_*
//     slave   sequencer side: observes dn_*, drives rom_*
interface rom_load_sequencer_if #(
  parameter int NUM_REGIONS = 4,
  parameter int REGION_AW   = 12
);
  logic                   dn_download;
  logic                   dn_wr;
  logic [15:0]            dn_addr;
  logic [7:0]             dn_data;
  logic [NUM_REGIONS-1:0] rom_we;
  logic [REGION_AW-1:0]   rom_addr;
  logic [7:0]             rom_data;

  modport master (
    output dn_download, dn_wr, dn_addr, dn_data,
    input  rom_we, rom_addr, rom_data
  );

  modport slave (
    input  dn_download, dn_wr, dn_addr, dn_data,
    output rom_we, rom_addr, rom_data
  );
endinterface

// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer
//   Routes the HPS ROM download stream into the core's ROM regions and owns
//   the core reset. Each accepted byte becomes a one-hot region strobe one
//   clock later. The core stays in reset while loading and for HOLD_CYCLES
//   clocks afterwards; a short download parks the sequencer in ERROR with
//   the core held in reset until a new download starts.
//   Ports:
//     clk         system clock
//     reset_n     asynchronous active-low reset
//     bus         download/ROM bundle (slave modport)
//     user_reset  reset request from menu/button (level)
//     core_reset  registered active-high reset to the game core
//     load_ok     last download reached EXPECTED_BYTES
//     load_err    last download was short
//     byte_count  accepted bytes of the current/last download (saturating)
//     checksum    additive mod-256 checksum of accepted bytes
//   Build option:
//     LOADER_CHECKSUM_EN  when defined the checksum accumulator is built;
//                         otherwise checksum is tied to 8'h00.
module rom_load_sequencer #(
  parameter int NUM_REGIONS    = 4,
  parameter int REGION_AW      = 12,
  parameter int EXPECTED_BYTES = 16384,
  parameter int HOLD_CYCLES    = 1024
) (
  input  logic                 clk,
  input  logic                 reset_n,
  rom_load_sequencer_if.slave  bus,
  input  logic                 user_reset,
  output logic                 core_reset,
  output logic                 load_ok,
  output logic                 load_err,
  output logic [16:0]          byte_count,
  output logic [7:0]           checksum
);
  localparam int              CNT_W      = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES);
  localparam logic [16:0]     ADDR_LIMIT = 17'(NUM_REGIONS) << REGION_AW;
  localparam logic [16:0]     EXP_COUNT  = 17'(EXPECTED_BYTES);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_HOLD  = 3'd2,
    S_RUN   = 3'd3,
    S_ERROR = 3'd4
  } state_t;

  function automatic logic [16:0] sat_inc(input logic [16:0] v);
    return (v == '1) ? v : v + 17'd1;
  endfunction

  state_t                 r_state;
  logic [CNT_W-1:0]       r_hold_cnt;
  logic                   r_core_reset;
  logic                   r_load_ok;
  logic                   r_load_err;
  logic [16:0]            r_byte_count;
  logic [NUM_REGIONS-1:0] r_rom_we;
  logic [REGION_AW-1:0]   r_rom_addr;
  logic [7:0]             r_rom_data;

  logic                   w_accept;
  logic                   w_enter_load;
  logic [2:0]             w_region;
  logic [NUM_REGIONS-1:0] w_region_we;
  logic [16:0]            w_count_next;

  // Only the LOAD state looks at dn_wr; the edge on which dn_download rises
  // still sees the previous state, so that cycle's write is dropped.
  assign w_accept     = (r_state == S_LOAD) && bus.dn_wr &&
                        ({1'b0, bus.dn_addr} < ADDR_LIMIT);
  // Every state other than LOAD jumps to LOAD on dn_download, and that
  // outranks user_reset everywhere.
  assign w_enter_load = (r_state != S_LOAD) && bus.dn_download;
  assign w_region     = bus.dn_addr[REGION_AW+2:REGION_AW];
  assign w_region_we  = NUM_REGIONS'(1) << w_region;
  // A write in the same cycle dn_download falls still counts toward the
  // length check.
  assign w_count_next = w_accept ? sat_inc(r_byte_count) : r_byte_count;

  // Write path register stage: strobe for exactly one cycle, address/data hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rom_we   <= '0;
      r_rom_addr <= '0;
      r_rom_data <= '0;
    end else begin
      r_rom_we <= '0;
      if (w_accept) begin
        r_rom_we   <= w_region_we;
        r_rom_addr <= bus.dn_addr[REGION_AW-1:0];
        r_rom_data <= bus.dn_data;
      end
    end
  end

  // Sequencer state, hold counter and status registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_hold_cnt   <= '0;
      r_core_reset <= 1'b1;
      r_load_ok    <= 1'b0;
      r_load_err   <= 1'b0;
      r_byte_count <= '0;
    end else begin
      // Derived from the state before this edge, so core_reset lags every
      // transition into or out of RUN by one clock.
      r_core_reset <= (r_state != S_RUN);
      if (w_enter_load) begin
        r_state      <= S_LOAD;
        r_byte_count <= '0;
        r_load_ok    <= 1'b0;
        r_load_err   <= 1'b0;
      end else begin
        case (r_state)
          S_LOAD: begin
            r_byte_count <= w_count_next;
            if (!bus.dn_download) begin
              if (w_count_next >= EXP_COUNT) begin
                r_load_ok  <= 1'b1;
                r_hold_cnt <= HOLD_LOAD;
                r_state    <= S_HOLD;
              end else begin
                r_load_err <= 1'b1;
                r_state    <= S_ERROR;
              end
            end
          end
          S_HOLD: begin
            // A held user_reset keeps reloading, stretching the hold.
            if (user_reset) begin
              r_hold_cnt <= HOLD_LOAD;
            end else if (r_hold_cnt == CNT_W'(1)) begin
              r_state <= S_RUN;
            end else begin
              r_hold_cnt <= r_hold_cnt - CNT_W'(1);
            end
          end
          S_RUN: begin
            if (user_reset) begin
              r_hold_cnt <= HOLD_LOAD;
              r_state    <= S_HOLD;
            end
          end
          S_IDLE, S_ERROR: begin
            // Both wait for a new download; ERROR ignores user_reset.
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  logic [7:0] r_checksum;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_checksum <= '0;
    end else if (w_enter_load) begin
      r_checksum <= '0;
    end else if (w_accept) begin
      r_checksum <= r_checksum + bus.dn_data;
    end
  end

  assign checksum = r_checksum;
`else
  assign checksum = 8'h00;
`endif

  assign bus.rom_we   = r_rom_we;
  assign bus.rom_addr = r_rom_addr;
  assign bus.rom_data = r_rom_data;
  assign core_reset   = r_core_reset;
  assign load_ok      = r_load_ok;
  assign load_err     = r_load_err;
  assign byte_count   = r_byte_count;
endmodule

// File: tb/tb_rom_load_sequencer.sv
// tb_rom_load_sequencer
//   Self-checking bench for rom_load_sequencer. Stimulus is driven one clock
//   at a time; outputs are observed 1 time unit after the rising edge. The
//   expected strobes, counts and checksums come from a byte-level model
//   (address / region size arithmetic, running sum of accepted data).
module tb_rom_load_sequencer;
  localparam int NR  = 4;
  localparam int AW  = 12;
  localparam int EXP = 16384;
  localparam int H   = 1024;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        user_reset = 1'b0;
  logic        core_reset;
  logic        load_ok;
  logic        load_err;
  logic [16:0] byte_count;
  logic [7:0]  checksum;

  rom_load_sequencer_if #(.NUM_REGIONS(NR), .REGION_AW(AW)) dl();

  rom_load_sequencer #(
    .NUM_REGIONS(NR), .REGION_AW(AW), .EXPECTED_BYTES(EXP), .HOLD_CYCLES(H)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(dl), .user_reset(user_reset),
    .core_reset(core_reset), .load_ok(load_ok), .load_err(load_err),
    .byte_count(byte_count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  int         model_count = 0;
  logic [7:0] model_sum = 8'h00;

  function automatic bit in_range(input int addr);
    return addr < (NR * (1 << AW));
  endfunction

  function automatic logic [NR-1:0] exp_we(input int addr);
    logic [NR-1:0] v;
    v = '0;
    if (in_range(addr)) v[addr / (1 << AW)] = 1'b1;
    return v;
  endfunction

  function automatic logic [7:0] exp_csum();
`ifdef LOADER_CHECKSUM_EN
    return model_sum;
`else
    return 8'h00;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive n consecutive byte writes starting at addr start; the download
  // level is left as the caller set it. Updates the model only.
  task automatic push_bytes(input int n, input int start, input bit rnd);
    for (int i = 0; i < n; i++) begin
      int         a;
      logic [7:0] d;
      a = start + i;
      d = rnd ? 8'($urandom) : 8'(a);
      dl.dn_wr   = 1'b1;
      dl.dn_addr = 16'(a);
      dl.dn_data = d;
      tick();
      if (in_range(a)) begin
        model_count++;
        model_sum = model_sum + d;
      end
    end
    dl.dn_wr = 1'b0;
  endtask

  // Raise dn_download with a write in the same cycle (that write must drop).
  task automatic begin_load();
    dl.dn_download = 1'b1;
    dl.dn_wr       = 1'b1;
    dl.dn_addr     = 16'($urandom_range(0, EXP - 1));
    dl.dn_data     = 8'($urandom);
    tick();
    dl.dn_wr    = 1'b0;
    model_count = 0;
    model_sum   = 8'h00;
  endtask

  task automatic end_load();
    dl.dn_download = 1'b0;
    dl.dn_wr       = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    dl.dn_download = 1'b0;
    dl.dn_wr       = 1'b0;
    dl.dn_addr     = '0;
    dl.dn_data     = '0;
    reset_n        = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (core_reset !== 1'b1 || dl.rom_we !== '0 || dl.rom_addr !== '0 || dl.rom_data !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: core_reset=%b rom_we=%b rom_addr=%h rom_data=%h, required 1 0 0 0",
               core_reset, dl.rom_we, dl.rom_addr, dl.rom_data);
    end
    n_checks++;
    if (load_ok !== 1'b0 || load_err !== 1'b0 || byte_count !== 17'd0 || checksum !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_status: ok=%b err=%b count=%0d sum=%h, required 0 0 0 00",
               load_ok, load_err, byte_count, checksum);
    end
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      dl.dn_wr   = 1'b1;
      dl.dn_addr = 16'($urandom_range(0, EXP - 1));
      tick();
      n_checks++;
      if (dl.rom_we !== '0 || core_reset !== 1'b1 || byte_count !== 17'd0) begin
        n_errors++;
        $display("FAIL idle_ignores_wr: rom_we=%b core_reset=%b count=%0d, required 0 1 0",
                 dl.rom_we, core_reset, byte_count);
      end
    end
    dl.dn_wr = 1'b0;
  endtask

  task automatic test_full_load();
    int             region_cnt[NR];
    logic [AW-1:0]  last_addr;
    logic [7:0]     last_data;
    int             fall;
    for (int r = 0; r < NR; r++) region_cnt[r] = 0;
    last_addr = '0;
    last_data = '0;
    begin_load();
    n_checks++;
    if (dl.rom_we !== '0 || byte_count !== 17'd0) begin
      n_errors++;
      $display("FAIL full_rise_write_dropped: rom_we=%b count=%0d, required 0 0", dl.rom_we, byte_count);
    end
    for (int a = 0; a < EXP; a++) begin
      if ($urandom_range(0, 15) == 0) begin
        dl.dn_wr = 1'b0;
        tick();
        n_checks++;
        if (dl.rom_we !== '0 || dl.rom_addr !== last_addr || dl.rom_data !== last_data) begin
          n_errors++;
          $display("FAIL full_gap_hold: rom_we=%b addr=%h data=%h, required 0 %h %h",
                   dl.rom_we, dl.rom_addr, dl.rom_data, last_addr, last_data);
        end
      end
      dl.dn_wr   = 1'b1;
      dl.dn_addr = 16'(a);
      dl.dn_data = 8'(a);
      tick();
      model_count++;
      model_sum = model_sum + 8'(a);
      last_addr = AW'(a);
      last_data = 8'(a);
      n_checks++;
      if (dl.rom_we !== exp_we(a) || dl.rom_addr !== last_addr || dl.rom_data !== last_data) begin
        n_errors++;
        $display("FAIL full_strobe a=%h: rom_we=%b addr=%h data=%h, required %b %h %h",
                 a, dl.rom_we, dl.rom_addr, dl.rom_data, exp_we(a), last_addr, last_data);
      end
      for (int r = 0; r < NR; r++) if (dl.rom_we[r] === 1'b1) region_cnt[r]++;
    end
    dl.dn_wr = 1'b0;
    n_checks++;
    if (byte_count !== 17'(model_count) || checksum !== exp_csum() || load_ok !== 1'b0) begin
      n_errors++;
      $display("FAIL full_totals: count=%0d sum=%h ok=%b, required %0d %h 0",
               byte_count, checksum, load_ok, model_count, exp_csum());
    end
    for (int r = 0; r < NR; r++) begin
      n_checks++;
      if (region_cnt[r] != (1 << AW)) begin
        n_errors++;
        $display("FAIL full_region_strobes r=%0d: got %0d, required %0d", r, region_cnt[r], 1 << AW);
      end
    end
    end_load();
    n_checks++;
    if (load_ok !== 1'b1 || load_err !== 1'b0 || core_reset !== 1'b1 || checksum !== 8'h00) begin
      n_errors++;
      $display("FAIL full_done: ok=%b err=%b core_reset=%b sum=%h, required 1 0 1 00",
               load_ok, load_err, core_reset, checksum);
    end
    fall = 0;
    for (int j = 1; j <= H + 20; j++) begin
      tick();
      if (core_reset === 1'b0) begin
        fall = j;
        break;
      end
    end
    n_checks++;
    if (fall != H + 1) begin
      n_errors++;
      $display("FAIL full_release_time: core_reset fell after %0d clocks, required %0d", fall, H + 1);
    end
  endtask

  task automatic test_user_reset();
    int highs;
    bit done;
    n_checks++;
    if (core_reset !== 1'b0) begin
      n_errors++;
      $display("FAIL ureset_pre_run: core_reset=%b, required 0", core_reset);
    end
    highs = 0;
    done  = 1'b0;
    user_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (core_reset === 1'b1) highs++;
    end
    user_reset = 1'b0;
    for (int j = 0; j < H + 50; j++) begin
      tick();
      if (core_reset === 1'b1) highs++;
      else begin
        done = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!done || highs != H + 2) begin
      n_errors++;
      $display("FAIL ureset_pulse: core_reset high %0d clocks (released=%0d), required %0d",
               highs, done, H + 2);
    end
    n_checks++;
    if (load_ok !== 1'b1 || load_err !== 1'b0) begin
      n_errors++;
      $display("FAIL ureset_status: ok=%b err=%b, required 1 0", load_ok, load_err);
    end
  endtask

  task automatic test_short_load();
    bit released;
    begin_load();
    push_bytes(100, 0, 1'b1);
    end_load();
    n_checks++;
    if (load_err !== 1'b1 || load_ok !== 1'b0) begin
      n_errors++;
      $display("FAIL short_flags: ok=%b err=%b, required 0 1", load_ok, load_err);
    end
    n_checks++;
    if (byte_count !== 17'(model_count) || checksum !== exp_csum()) begin
      n_errors++;
      $display("FAIL short_totals: count=%0d sum=%h, required %0d %h",
               byte_count, checksum, model_count, exp_csum());
    end
    user_reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (core_reset !== 1'b1) begin
        n_errors++;
        $display("FAIL short_ureset_ignored: core_reset=%b, required 1", core_reset);
      end
    end
    user_reset = 1'b0;
    repeat (10) tick();
    n_checks++;
    if (core_reset !== 1'b1 || load_err !== 1'b1) begin
      n_errors++;
      $display("FAIL short_stays_blocked: core_reset=%b err=%b, required 1 1", core_reset, load_err);
    end
    // Recovery with a full download of random data.
    begin_load();
    n_checks++;
    if (load_err !== 1'b0 || byte_count !== 17'd0) begin
      n_errors++;
      $display("FAIL recover_clear: err=%b count=%0d, required 0 0", load_err, byte_count);
    end
    push_bytes(EXP, 0, 1'b1);
    end_load();
    n_checks++;
    if (load_ok !== 1'b1 || byte_count !== 17'(model_count) || checksum !== exp_csum()) begin
      n_errors++;
      $display("FAIL recover_totals: ok=%b count=%0d sum=%h, required 1 %0d %h",
               load_ok, byte_count, checksum, model_count, exp_csum());
    end
    released = 1'b0;
    for (int j = 0; j < H + 20; j++) begin
      tick();
      if (core_reset === 1'b0) begin
        released = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!released) begin
      n_errors++;
      $display("FAIL recover_release: core_reset=%b after %0d clocks, required 0", core_reset, H + 20);
    end
  endtask

  task automatic test_out_of_range();
    int oor[3];
    oor[0] = 16'h4000;
    oor[1] = 16'hFFFF;
    oor[2] = $urandom_range(16'h4001, 16'hFFFE);
    begin_load();
    push_bytes(10, 0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      dl.dn_wr   = 1'b1;
      dl.dn_addr = 16'(oor[i]);
      dl.dn_data = 8'($urandom);
      tick();
      n_checks++;
      if (dl.rom_we !== '0 || byte_count !== 17'(model_count) || checksum !== exp_csum()) begin
        n_errors++;
        $display("FAIL oor_dropped addr=%h: rom_we=%b count=%0d sum=%h, required 0 %0d %h",
                 oor[i], dl.rom_we, byte_count, checksum, model_count, exp_csum());
      end
    end
    dl.dn_wr = 1'b0;
  endtask

  // Continues the download opened by test_out_of_range.
  task automatic test_boundary();
    logic [7:0] d;
    bit         released;
    push_bytes(EXP - 1 - model_count, model_count, 1'b1);
    d = 8'($urandom);
    dl.dn_download = 1'b0;
    dl.dn_wr       = 1'b1;
    dl.dn_addr     = 16'(EXP - 1);
    dl.dn_data     = d;
    tick();
    dl.dn_wr = 1'b0;
    model_count++;
    model_sum = model_sum + d;
    n_checks++;
    if (dl.rom_we !== exp_we(EXP - 1) || dl.rom_addr !== AW'(EXP - 1) || dl.rom_data !== d) begin
      n_errors++;
      $display("FAIL boundary_strobe: rom_we=%b addr=%h data=%h, required %b %h %h",
               dl.rom_we, dl.rom_addr, dl.rom_data, exp_we(EXP - 1), AW'(EXP - 1), d);
    end
    n_checks++;
    if (byte_count !== 17'(EXP) || load_ok !== 1'b1 || load_err !== 1'b0 || checksum !== exp_csum()) begin
      n_errors++;
      $display("FAIL boundary_status: count=%0d ok=%b err=%b sum=%h, required %0d 1 0 %h",
               byte_count, load_ok, load_err, checksum, EXP, exp_csum());
    end
    released = 1'b0;
    for (int j = 0; j < H + 20; j++) begin
      tick();
      if (core_reset === 1'b0) begin
        released = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!released) begin
      n_errors++;
      $display("FAIL boundary_release: core_reset=%b, required 0", core_reset);
    end
  endtask

  task automatic test_async_reset();
    begin_load();
    push_bytes(5000, 0, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if (core_reset !== 1'b1 || dl.rom_we !== '0 || dl.rom_addr !== '0 || dl.rom_data !== '0) begin
      n_errors++;
      $display("FAIL async_outputs: core_reset=%b rom_we=%b addr=%h data=%h, required 1 0 0 0",
               core_reset, dl.rom_we, dl.rom_addr, dl.rom_data);
    end
    n_checks++;
    if (load_ok !== 1'b0 || load_err !== 1'b0 || byte_count !== 17'd0 || checksum !== 8'h00) begin
      n_errors++;
      $display("FAIL async_status: ok=%b err=%b count=%0d sum=%h, required 0 0 0 00",
               load_ok, load_err, byte_count, checksum);
    end
    dl.dn_download = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      dl.dn_wr   = 1'b1;
      dl.dn_addr = 16'($urandom_range(0, EXP - 1));
      dl.dn_data = 8'($urandom);
      tick();
      n_checks++;
      if (dl.rom_we !== '0 || byte_count !== 17'd0 || core_reset !== 1'b1) begin
        n_errors++;
        $display("FAIL async_idle_ignores_wr: rom_we=%b count=%0d core_reset=%b, required 0 0 1",
                 dl.rom_we, byte_count, core_reset);
      end
    end
    dl.dn_wr = 1'b0;
    begin_load();
    n_checks++;
    if (dl.rom_we !== '0 || byte_count !== 17'd0) begin
      n_errors++;
      $display("FAIL async_reload_rise: rom_we=%b count=%0d, required 0 0", dl.rom_we, byte_count);
    end
    push_bytes(3, 16'h1000, 1'b1);
    n_checks++;
    if (dl.rom_we !== exp_we(16'h1002) || byte_count !== 17'(model_count)) begin
      n_errors++;
      $display("FAIL async_reload_write: rom_we=%b count=%0d, required %b %0d",
               dl.rom_we, byte_count, exp_we(16'h1002), model_count);
    end
    end_load();
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_user_reset();
    test_short_load();
    test_out_of_range();
    test_boundary();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
